// File: rtl/mips_pkg.sv
// Shared run-control types and defaults for the MIPS datapath wrapper.
// State encoding matches the `state` readout seen by debug software.
package mips_pkg;

  typedef enum logic [1:0] {
    RST_HOLD = 2'd0,
    RUN      = 2'd1,
    HALTED   = 2'd2,
    STEP     = 2'd3
  } run_state_t;

  localparam int DEF_CNT_W = 32;

endpackage

// File: rtl/mips_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
// Used for the cycle and retired-instruction counters.
module mips_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_reg;

  // Holds at all-ones once reached, so long runs read as "at least max".
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_reg <= '0;
    end else if (inc && !(&q_reg)) begin
      q_reg <= q_reg + 1'b1;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/mips_run_ctrl.sv
// Run control for the MIPS datapath: reset stretching, run/halt/step gating and
// saturating perf counters. Define MIPS_RUNCTRL_WDOG_EN to add the step watchdog.
module mips_run_ctrl
  import mips_pkg::*;
#(
  parameter int RST_CYCLES  = 4,
  parameter int CNT_W       = DEF_CNT_W,
  parameter bit BOOT_HALTED = 1'b0,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             halt_req,
  input  logic             resume_req,
  input  logic             step_req,
  input  logic             core_halt,
  input  logic             retire,
  output logic             core_rst_n,
  output logic             core_en,
  output logic [1:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt,
  output logic             wdog_to
);

  localparam int HOLD_W = $clog2(RST_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);

  if (RST_CYCLES < 1) begin : g_bad_rst_cycles
    $error("mips_run_ctrl: RST_CYCLES must be at least 1");
  end
  if (WDOG_CYCLES < 1) begin : g_bad_wdog_cycles
    $error("mips_run_ctrl: WDOG_CYCLES must be at least 1");
  end

  run_state_t        state_reg;
  run_state_t        state_next;
  logic [HOLD_W-1:0] hold_cnt_reg;
  logic              hold_done;
  logic              stop_req;
  logic              wdog_hit;
  logic              core_rst_n_reg;
  logic              core_en_reg;
  logic              halted_reg;

  assign hold_done = (hold_cnt_reg == HOLD_LAST);
  assign stop_req  = halt_req | core_halt;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RST_HOLD: begin
        if (hold_done) begin
          state_next = BOOT_HALTED ? HALTED : RUN;
        end
      end
      RUN: begin
        if (stop_req) begin
          state_next = HALTED;
        end
      end
      HALTED: begin
        if (halt_req) begin
          state_next = HALTED;
        end else if (resume_req) begin
          state_next = RUN;
        end else if (step_req) begin
          state_next = STEP;
        end
      end
      STEP: begin
        // A retire or stop coincident with watchdog expiry ends the step normally.
        if (retire || stop_req || wdog_hit) begin
          state_next = HALTED;
        end
      end
      default: state_next = RST_HOLD;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= RST_HOLD;
      hold_cnt_reg   <= '0;
      core_rst_n_reg <= 1'b0;
      core_en_reg    <= 1'b0;
      halted_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      if (state_reg == RST_HOLD && !hold_done) begin
        hold_cnt_reg <= hold_cnt_reg + 1'b1;
      end
      core_rst_n_reg <= (state_next != RST_HOLD);
      core_en_reg    <= (state_next == RUN) || (state_next == STEP);
      halted_reg     <= (state_next == HALTED);
    end
  end

`ifdef MIPS_RUNCTRL_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

  logic [WDOG_W-1:0] wdog_cnt_reg;
  logic              wdog_to_reg;
  logic              wdog_fire;

  assign wdog_hit  = (state_reg == STEP) && (wdog_cnt_reg == WDOG_LAST);
  assign wdog_fire = wdog_hit && !retire && !stop_req;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog_cnt_reg <= '0;
      wdog_to_reg  <= 1'b0;
    end else begin
      if (state_next == STEP && state_reg != STEP) begin
        wdog_cnt_reg <= '0;
      end else if (state_reg == STEP && !wdog_hit) begin
        wdog_cnt_reg <= wdog_cnt_reg + 1'b1;
      end
      if (wdog_fire) begin
        wdog_to_reg <= 1'b1;
      end
    end
  end

  assign wdog_to = wdog_to_reg;
`else
  assign wdog_hit = 1'b0;
  assign wdog_to  = 1'b0;
`endif

  // Index 0 counts enabled cycles, index 1 counts retirements while enabled.
  logic [1:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_q [2];

  assign cnt_inc[0] = core_en_reg;
  assign cnt_inc[1] = core_en_reg & retire;

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    mips_sat_counter #(
      .W(CNT_W)
    ) u_cnt (
      .clk  (clk),
      .reset(reset),
      .inc  (cnt_inc[gi]),
      .q    (cnt_q[gi])
    );
  end

  assign core_rst_n  = core_rst_n_reg;
  assign core_en     = core_en_reg;
  assign state       = state_reg;
  assign halted      = halted_reg;
  assign cycle_cnt   = cnt_q[0];
  assign instret_cnt = cnt_q[1];

endmodule

// File: doc/mips_run_ctrl.md
Name: mips_run_ctrl

Overview:
- Parametrised run-control block that sits between the top-level reset/clock and the MIPS datapath.
- Stretches and sequences datapath reset, then gates execution through `core_en`.
- Supports halt, resume and single-step requests.
- Keeps saturating cycle and retired-instruction counters for debug and performance readout.

Parameters:
- `RST_CYCLES`, 4: cycles `core_rst_n` is held low after `reset` deasserts; must be ≥1.
- `CNT_W`, 32: width of `cycle_cnt` and `instret_cnt`.
- `BOOT_HALTED`, 0: 1 means leave reset-hold into HALTED instead of RUN.
- `WDOG_CYCLES`, 1024: step watchdog limit; used only with the optional feature.

Ports:
- `clk` in 1: core clock.
- `reset` in 1: asynchronous, active-low reset.
- `halt_req` in 1: level-sampled request to halt.
- `resume_req` in 1: level-sampled request to run.
- `step_req` in 1: level-sampled request to execute exactly one instruction.
- `core_halt` in 1: datapath-raised halt (break/syscall trap).
- `retire` in 1: one-cycle pulse per retired instruction; qualified by `core_en`.
- `core_rst_n` out 1: registered, active-low datapath reset.
- `core_en` out 1: registered execute enable (stall when 0).
- `state` out 2: current FSM state.
- `halted` out 1: high in HALTED.
- `cycle_cnt` out `CNT_W`: cycles with `core_en`=1.
- `instret_cnt` out `CNT_W`: retired instructions.
- `wdog_to` out 1: sticky step-timeout flag.

Behaviour:
- Reset (`reset`=0, async):
  - state=RST_HOLD, `core_rst_n`=0, `core_en`=0, `halted`=0.
  - `cycle_cnt`, `instret_cnt`, hold counter and watchdog counter all 0; `wdog_to`=0.
  - Reset asserted mid-operation aborts everything immediately, including STEP.
- State encoding: RST_HOLD=0, RUN=1, HALTED=2, STEP=3.
- RST_HOLD:
  - Hold counter increments each cycle after `reset` deasserts.
  - When it reaches `RST_CYCLES`-1, `core_rst_n` goes 1 and the next state is RUN, or HALTED if `BOOT_HALTED`=1.
  - `core_rst_n` low for exactly `RST_CYCLES` rising edges after deassertion.
  - Requests are ignored in RST_HOLD.
- RUN:
  - `core_en`=1.
  - `halt_req`|`core_halt` sampled high at edge k → state=HALTED and `core_en`=0 from edge k; one-cycle latency from request to stall.
  - `resume_req`/`step_req` ignored.
- HALTED:
  - `core_en`=0, `halted`=1.
  - Priority: `halt_req` (stay) > `resume_req` (→RUN) > `step_req` (→STEP).
  - `core_en` rises at the same edge the state changes.
- STEP:
  - `core_en`=1 until `retire` is sampled high, then → HALTED with `core_en`=0 at that edge; exactly one `retire` counted.
  - `halt_req`|`core_halt` in STEP → HALTED the same way; a coincident `retire` is still counted.
  - `step_req` held high does not chain steps; a new step needs HALTED→STEP again.
- Counters:
  - `cycle_cnt` += 1 on each edge where `core_en`=1.
  - `instret_cnt` += 1 on each edge where `retire`&`core_en`.
  - Both saturate at 2^`CNT_W`-1 (no wrap).
  - A `retire` seen while `core_en`=0 is ignored.
- Outputs are all registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: `MIPS_RUNCTRL_WDOG_EN`.
- Defined:
  - A watchdog counter runs in STEP and clears on STEP entry.
  - If `WDOG_CYCLES` cycles elapse in STEP with no `retire`, the state goes to HALTED, `core_en`=0 and `wdog_to`=1.
  - `wdog_to` is sticky until `reset`.
  - Any `retire` before the limit ends the step normally.
- Undefined: no watchdog logic; `wdog_to` is tied 0 and STEP waits indefinitely.

Decomposition:
- Shared package `mips_pkg` holds:
  - the 2-bit `run_state_t` typedef;
  - the state localparams `RST_HOLD`/`RUN`/`HALTED`/`STEP`;
  - the default `CNT_W`.
- One natural sub-module, `mips_sat_counter`:
  - parameter `W`; inputs `clk`, `reset`, `inc`; output `q`;
  - saturating, async active-low clear;
  - instantiated twice, for cycle and instret.

Test Plan:
1. Boot with `RST_CYCLES`=4, `BOOT_HALTED`=0: deassert `reset` → `core_rst_n` low for 4 edges, then `core_rst_n`=1, state=RUN, `core_en`=1 on the next edge.
2. RUN with `retire` every cycle for 10 cycles, then `halt_req` pulse → `core_en`=0 one edge after sampling; `instret_cnt`=10, `cycle_cnt`=10, `halted`=1.
3. In HALTED, assert `step_req` and `resume_req` together → RUN (resume wins). Separately, `step_req` alone with `retire` 3 cycles later → HALTED, `instret_cnt` +1 exactly, `cycle_cnt` +3.
4. Use `CNT_W`=4 and run 20 cycles → `cycle_cnt` holds 15 and does not wrap.
5. Assert `reset`=0 mid-STEP → all outputs return to reset values asynchronously, and the reset-hold sequence restarts.
6. With `MIPS_RUNCTRL_WDOG_EN` and `WDOG_CYCLES`=8, STEP with no `retire` → after 8 cycles state=HALTED, `wdog_to`=1 and it stays 1 through subsequent RUN/HALT cycles.
